dispense_sequencer: RTL
=======================

# dispense_sequencer

- Sequences one dispensing job for the water dispenser.
- Takes the confirmed order amount from the front-panel logic (switches, add, ok and cancel buttons produce `total_amount`).
- Opens the valve, meters the flow in fixed clock ticks per unit, pauses while the cup is absent, and reports completion or abort.
- Sits between the order-entry logic and the valve driver.

## Interface
- AMOUNT_WIDTH, 8, width of amount, remaining and dispensed counts
- TICKS_PER_UNIT, 5, clock cycles of open valve per dispensed unit (≥1)
- SETTLE_CYCLES, 2, open-valve cycles before metering starts, after every (re)open (≥1)

- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request to dispense `amount`; sampled each cycle
- amount  in  AMOUNT_WIDTH  units to dispense, latched when start is accepted
- cancel  in  1  abort the current job
- cup_present  in  1  level; 0 means the cup has been removed
- valve_open  out  1  valve drive
- busy  out  1  job in progress, including the FINISH cycle
- remaining  out  AMOUNT_WIDTH  units still to dispense
- dispensed  out  AMOUNT_WIDTH  units dispensed in the current or last job
- done  out  1  one-cycle pulse: job completed
- aborted  out  1  one-cycle pulse: job cancelled

## Operation
- **States:** IDLE, SETTLE, FLOW, PAUSE, FINISH.
- **Reset value:** IDLE; every output is 0.
- **IDLE:**
  - start=1 with amount≠0: latch remaining=amount, dispensed=0, clear the tick and settle counters.
  - Next state is SETTLE if cup_present, else PAUSE.
  - start with amount=0 is ignored: no pulse, no state change.
  - cancel is ignored.
- **SETTLE:**
  - valve_open=1.
  - After SETTLE_CYCLES cycles in SETTLE, go to FLOW.
- **FLOW:**
  - valve_open=1; the tick counter increments each cycle.
  - On the cycle where tick==TICKS_PER_UNIT-1: tick←0, remaining−1, dispensed+1.
  - If remaining becomes 0, go to FINISH with done.
- **PAUSE:**
  - valve_open=0; the tick counter is held, so a partial unit is preserved.
  - cup_present=1 goes to SETTLE; the settle counter restarts.
- **Cup removal:** cup_present=0 in SETTLE or FLOW goes to PAUSE next cycle. A unit completing in that same cycle is still counted.
- **Cancel:** cancel=1 in SETTLE, FLOW or PAUSE goes to FINISH with aborted. Cancel has priority over cup removal and over unit completion, so a unit finishing in the cancel cycle is not counted.
- **FINISH:**
  - Lasts one cycle; valve_open=0, busy=1.
  - Exactly one of done or aborted is high.
  - Next state is IDLE.
- **Counters after a job:** remaining and dispensed hold their values until the next accepted start.
- **Invariant:** remaining+dispensed equals the latched amount at all times during a job.
- **Busy behaviour:** start while busy is ignored; amount changes while busy have no effect.
- **Mid-operation reset:** goes to IDLE next cycle; valve closes, counts clear, no done/aborted pulse.

## Timing
- All outputs are decoded from or held in registers; there is no combinational input→output path.
- **Start latency:** start accepted at edge 0 (cup present) gives valve_open=1 from cycle 1.
- **Uninterrupted job of N units:**
  - valve_open is high for exactly SETTLE_CYCLES + N·TICKS_PER_UNIT cycles.
  - done is high in the following cycle.
  - busy falls one cycle after done.
- **Unit counting:** remaining decrements on the edge ending each TICKS_PER_UNIT-th FLOW cycle of a unit.
- **Cup removal:** cup_present falling at edge k gives valve_open=0 in cycle k+1.
- **Cup return:** cup_present rising during PAUSE reopens the valve the next cycle, followed by SETTLE_CYCLES again.
- **Cancel:** cancel at edge k gives FINISH and aborted in cycle k+1; valve_open=0 in that cycle.

## Structure
- **Shared package `water_dispenser_pkg`:**
  - State encoding localparams (IDLE…FINISH).
  - Default TICKS_PER_UNIT and SETTLE_CYCLES.
  - Amount width, which the order-entry logic also uses.
- **Sub-module `dispense_timer`:**
  - Parameterised modulo counter with clear, enable and hold.
  - Provides a terminal-count flag.
  - Instantiated twice: once for settle, once for ticks per unit.

## Test plan
- **Normal job:** defaults, cup present, start with amount=3 → valve_open high for 17 cycles, remaining steps 3→2→1→0, done in cycle 18, dispensed=3, busy low in cycle 19.
- **Cup removal:** amount=2, cup removed after 7 FLOW cycles (tick=2 of unit 2).
  - Valve closes next cycle; remaining=1, dispensed=1 are held.
  - On cup return: 2 settle cycles, then 3 more ticks, then done; total open time 2+7+2+3=14.
- **Cancel:** cancel asserted in the same cycle as a unit completion (amount=4, 2nd unit) → aborted pulse, no done, dispensed=1, remaining=3.
- **Ignored starts:** start with amount=0, start while busy, and start in the same cycle as cancel while IDLE.
  - amount=0 and start-while-busy produce no effect.
  - start with cancel in IDLE starts the job normally.
- **Start without cup:** start with cup absent → PAUSE, valve_open stays 0 until cup_present=1, then a normal job.
- **Reset mid-job:** reset during FLOW → next cycle valve_open=0, busy=0, remaining=0, dispensed=0, no pulse.

Source files
------------

// File: rtl/water_dispenser_pkg.sv
// rtl/water_dispenser_pkg.sv - shared types and defaults for the water dispenser
package water_dispenser_pkg;

  localparam int unsigned DEF_AMOUNT_WIDTH   = 8;
  localparam int unsigned DEF_TICKS_PER_UNIT = 5;
  localparam int unsigned DEF_SETTLE_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_FLOW   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/dispense_sequencer_if.sv
// rtl/dispense_sequencer_if.sv - job request and valve/status signals of the dispense sequencer
interface dispense_sequencer_if
  import water_dispenser_pkg::*;
#(
  parameter int unsigned AMOUNT_WIDTH = DEF_AMOUNT_WIDTH
) ();

  logic                    start;
  logic [AMOUNT_WIDTH-1:0] amount;
  logic                    cancel;
  logic                    cup_present;
  logic                    valve_open;
  logic                    busy;
  logic [AMOUNT_WIDTH-1:0] remaining;
  logic [AMOUNT_WIDTH-1:0] dispensed;
  logic                    done;
  logic                    aborted;

  modport master (
    output start, amount, cancel, cup_present,
    input  valve_open, busy, remaining, dispensed, done, aborted
  );

  modport slave (
    input  start, amount, cancel, cup_present,
    output valve_open, busy, remaining, dispensed, done, aborted
  );

endinterface

// File: rtl/dispense_timer.sv
// rtl/dispense_timer.sv - modulo counter with clear, enable and hold; flags the last count
module dispense_timer #(
  parameter int unsigned MODULO = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned W = (MODULO > 1) ? $clog2(MODULO) : 1;
  localparam logic [W-1:0] LAST = W'(MODULO - 1);

  logic [W-1:0] count_q, count_d;

  // clear wins over enable; with neither, the count is held
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == LAST);

endmodule

// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - runs one dispensing job: settle, metered flow, cup pause, done/abort
module dispense_sequencer
  import water_dispenser_pkg::*;
#(
  parameter int unsigned AMOUNT_WIDTH   = DEF_AMOUNT_WIDTH,
  parameter int unsigned TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  dispense_sequencer_if.slave  bus
);

  localparam logic [AMOUNT_WIDTH-1:0] ONE = AMOUNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [AMOUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [AMOUNT_WIDTH-1:0] dispensed_q, dispensed_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    tick_clr, tick_en, tick_tc;
  logic                    settle_tc;

  // Settle count restarts on every entry into SETTLE because it is held clear elsewhere
  dispense_timer #(.MODULO(SETTLE_CYCLES)) u_settle (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_SETTLE),
    .enable (state_q == ST_SETTLE),
    .tc     (settle_tc)
  );

  dispense_timer #(.MODULO(TICKS_PER_UNIT)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (tick_clr),
    .enable (tick_en),
    .tc     (tick_tc)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dispensed_d = dispensed_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    tick_clr    = 1'b0;
    tick_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.amount != '0)) begin
          remaining_d = bus.amount;
          dispensed_d = '0;
          tick_clr    = 1'b1;
          state_d     = bus.cup_present ? ST_SETTLE : ST_PAUSE;
        end
      end
      ST_SETTLE: begin
        if (bus.cancel) begin
          state_d   = ST_FINISH;
          aborted_d = 1'b1;
        end else if (!bus.cup_present) begin
          state_d = ST_PAUSE;
        end else if (settle_tc) begin
          state_d = ST_FLOW;
        end
      end
      ST_FLOW: begin
        if (bus.cancel) begin
          state_d   = ST_FINISH;
          aborted_d = 1'b1;
        end else begin
          tick_en = 1'b1;
          // A unit finishing on the cup-removal cycle is still counted
          if (tick_tc) begin
            remaining_d = remaining_q - ONE;
            dispensed_d = dispensed_q + ONE;
          end
          if (tick_tc && (remaining_q == ONE)) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else if (!bus.cup_present) begin
            state_d = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.cancel) begin
          state_d   = ST_FINISH;
          aborted_d = 1'b1;
        end else if (bus.cup_present) begin
          state_d = ST_SETTLE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      dispensed_q <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dispensed_q <= dispensed_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.valve_open = (state_q == ST_SETTLE) || (state_q == ST_FLOW);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.remaining  = remaining_q;
  assign bus.dispensed  = dispensed_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;

endmodule
